// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-unit bundle: pipeline register addresses and enables come in,
// forwarding, stall, flush, error and counter signals go out.
interface pipeline_hazard_ctrl_if #(
    parameter int CNTW = 16
);
    logic [4:0]      Rs1D, Rs2D;
    logic [4:0]      Rs1E, Rs2E, RdE;
    logic [4:0]      RdM, RdW;
    logic            RegWriteM, RegWriteW;
    logic [1:0]      ResultSrcE;
    logic            PCSrcE;
    logic            MemReqM, MemAckM;
    logic            CountClr;
    logic [1:0]      ForwardAE, ForwardBE;
    logic            StallF, StallD, StallE, StallM;
    logic            FlushD, FlushE, FlushW;
    logic            Error;
    logic [CNTW-1:0] StallCount, FlushCount;

    // Pipeline side: drives stage information, consumes hazard controls.
    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, ResultSrcE, PCSrcE,
        output MemReqM, MemAckM, CountClr,
        input  ForwardAE, ForwardBE,
        input  StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushW,
        input  Error, StallCount, FlushCount
    );

    // Hazard controller side.
    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE,
        input  MemReqM, MemAckM, CountClr,
        output ForwardAE, ForwardBE,
        output StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushW,
        output Error, StallCount, FlushCount
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: operand forwarding, load-use stall,
// branch flush, data-memory wait hold with timeout, and saturating
// stall/flush event counters. All hazard outputs are combinational.
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNTW    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    localparam logic [15:0]     TIMEOUT_L = 16'(TIMEOUT);
    localparam logic [CNTW-1:0] CNT_MAX   = {CNTW{1'b1}};

    state_t          state_q, state_d;
    logic [15:0]     wait_q, wait_d;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNTW-1:0] flush_cnt_q, flush_cnt_d;
    logic            mem_hold;
    logic            lw_stall;
    logic            stall_f;
    logic            flush_d;

    // Operand forwarding: memory stage result beats writeback result; x0 never forwards.
    logic [4:0] rs_e  [2];
    logic [1:0] fwd_e [2];
    assign rs_e[0] = hz.Rs1E;
    assign rs_e[1] = hz.Rs2E;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            // Per-operand forward select.
            always_comb begin
                fwd_e[gi] = 2'b00;
                if (hz.RegWriteM && (hz.RdM != 5'd0) && (hz.RdM == rs_e[gi])) begin
                    fwd_e[gi] = 2'b10;
                end else if (hz.RegWriteW && (hz.RdW != 5'd0) && (hz.RdW == rs_e[gi])) begin
                    fwd_e[gi] = 2'b01;
                end
            end
        end
    endgenerate

    assign hz.ForwardAE = fwd_e[0];
    assign hz.ForwardBE = fwd_e[1];

    // A load in execute whose destination is read by the decode instruction.
    assign lw_stall = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

    // Memory-wait FSM next state and the combinational hold it produces.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        mem_hold = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (hz.MemReqM && !hz.MemAckM) begin
                    mem_hold = 1'b1;
                    state_d  = ST_MEM_WAIT;
                    wait_d   = 16'd1;
                end
            end
            ST_MEM_WAIT: begin
                // An ack always wins, even in the cycle the timeout would fire.
                if (hz.MemAckM) begin
                    state_d = ST_RUN;
                    wait_d  = 16'd0;
                end else begin
                    mem_hold = 1'b1;
                    if (wait_q == TIMEOUT_L) begin
                        state_d = ST_ERROR;
                    end else begin
                        wait_d = wait_q + 16'd1;
                    end
                end
            end
            ST_ERROR: begin
                mem_hold = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
                wait_d  = 16'd0;
            end
        endcase
    end

    // While memory holds the pipe, freeze every stage and bubble writeback;
    // load-use and branch requests are deferred until the hold drops.
    assign stall_f   = mem_hold | lw_stall;
    assign flush_d   = !mem_hold & hz.PCSrcE;
    assign hz.StallF = stall_f;
    assign hz.StallD = stall_f;
    assign hz.StallE = mem_hold;
    assign hz.StallM = mem_hold;
    assign hz.FlushD = flush_d;
    assign hz.FlushE = !mem_hold & (lw_stall | hz.PCSrcE);
    assign hz.FlushW = mem_hold;
    assign hz.Error  = (state_q == ST_ERROR);

    // Saturating event counters; clear takes priority over counting.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hz.CountClr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_f && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (flush_d && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    assign hz.StallCount = stall_cnt_q;
    assign hz.FlushCount = flush_cnt_q;

    // State, wait counter and event counters register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            wait_q      <= 16'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;
    localparam int TIMEOUT = 4;
    localparam int CNTW    = 4;
    localparam int SAT     = (1 << CNTW) - 1;

    logic clk;
    logic reset;

    pipeline_hazard_ctrl_if #(.CNTW(CNTW)) ifc ();

    pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: error flag, cycles spent waiting (0 = not waiting), counters.
    bit m_err;
    int m_wait;
    int m_sc;
    int m_fc;

    function automatic logic [1:0] fwd_model(input logic [4:0] rs);
        if (ifc.RegWriteM && ifc.RdM != 0 && ifc.RdM == rs) return 2'b10;
        if (ifc.RegWriteW && ifc.RdW != 0 && ifc.RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Every-cycle compare against the model, then advance the model.
    always @(negedge clk) begin
        bit         lw;
        bit         hold;
        logic [6:0] exp_ctl;
        logic [6:0] act_ctl;
        if (!reset) begin
            m_err = 0; m_wait = 0; m_sc = 0; m_fc = 0;
        end
        lw   = (ifc.ResultSrcE == 2'b01) && (ifc.RdE != 0) &&
               (ifc.RdE == ifc.Rs1D || ifc.RdE == ifc.Rs2D);
        hold = m_err || ((m_wait > 0) ? !ifc.MemAckM : (ifc.MemReqM && !ifc.MemAckM));
        exp_ctl = hold ? 7'b1111100 : {lw, lw, 1'b0, 1'b0, 1'b0, ifc.PCSrcE, lw | ifc.PCSrcE};
        act_ctl = {ifc.StallF, ifc.StallD, ifc.StallE, ifc.StallM, ifc.FlushW, ifc.FlushD, ifc.FlushE};
        check("model_fwdA", 32'(ifc.ForwardAE), 32'(fwd_model(ifc.Rs1E)));
        check("model_fwdB", 32'(ifc.ForwardBE), 32'(fwd_model(ifc.Rs2E)));
        check("model_ctl", 32'(act_ctl), 32'(exp_ctl));
        check("model_err", 32'(ifc.Error), 32'(m_err));
        check("model_stallcnt", 32'(ifc.StallCount), 32'(m_sc));
        check("model_flushcnt", 32'(ifc.FlushCount), 32'(m_fc));
        if (reset) begin
            if (ifc.CountClr) begin
                m_sc = 0; m_fc = 0;
            end else begin
                if (hold || lw) m_sc = (m_sc < SAT) ? m_sc + 1 : SAT;
                if (!hold && ifc.PCSrcE) m_fc = (m_fc < SAT) ? m_fc + 1 : SAT;
            end
            if (!m_err) begin
                if (m_wait == 0) begin
                    if (ifc.MemReqM && !ifc.MemAckM) m_wait = 1;
                end else if (ifc.MemAckM) begin
                    m_wait = 0;
                end else if (m_wait == TIMEOUT) begin
                    m_err = 1; m_wait = 0;
                end else begin
                    m_wait++;
                end
            end
        end
    end

    task automatic idle();
        ifc.Rs1D = 0; ifc.Rs2D = 0; ifc.Rs1E = 0; ifc.Rs2E = 0; ifc.RdE = 0;
        ifc.RdM = 0; ifc.RdW = 0; ifc.RegWriteM = 0; ifc.RegWriteW = 0;
        ifc.ResultSrcE = 0; ifc.PCSrcE = 0; ifc.MemReqM = 0; ifc.MemAckM = 0;
        ifc.CountClr = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] ctl_now();
        return {ifc.StallF, ifc.StallD, ifc.StallE, ifc.StallM, ifc.FlushW, ifc.FlushD, ifc.FlushE};
    endfunction

    initial begin
        reset = 1'b0;
        idle();
        step();
        step();
        check("reset_err", 32'(ifc.Error), 0);
        check("reset_stallcnt", 32'(ifc.StallCount), 0);
        check("reset_flushcnt", 32'(ifc.FlushCount), 0);
        reset = 1'b1;
        #1 check("reset_idle_ctl", 32'(ctl_now()), 0);

        // Forwarding priority.
        step();
        ifc.RdM = 5; ifc.RdW = 5; ifc.Rs1E = 5; ifc.RegWriteM = 1; ifc.RegWriteW = 1;
        #1 check("fwd_mem", 32'(ifc.ForwardAE), 2);
        ifc.RegWriteM = 0;
        #1 check("fwd_wb", 32'(ifc.ForwardAE), 1);
        ifc.Rs1E = 0; ifc.RdM = 0; ifc.RdW = 0;
        #1 check("fwd_none", 32'(ifc.ForwardAE), 0);
        $display("forwarding scenario done");

        // Load-use stall.
        step(); idle(); ifc.CountClr = 1;
        step(); idle(); ifc.ResultSrcE = 2'b01; ifc.RdE = 3; ifc.Rs2D = 3;
        #1 check("lu_ctl", 32'(ctl_now()), 32'(7'b1100001));
        step(); idle();
        #1 check("lu_stallcnt", 32'(ifc.StallCount), 1);
        check("lu_flushcnt", 32'(ifc.FlushCount), 0);
        $display("load-use scenario done");

        // Branch together with load-use.
        ifc.PCSrcE = 1; ifc.ResultSrcE = 2'b01; ifc.RdE = 3; ifc.Rs1D = 3;
        #1 check("br_lu_ctl", 32'(ctl_now()), 32'(7'b1100011));
        step(); idle();
        #1 check("br_lu_flushcnt", 32'(ifc.FlushCount), 1);
        check("br_lu_stallcnt", 32'(ifc.StallCount), 2);
        $display("branch+load-use scenario done");

        // Memory wait of 4 held cycles; the ack lands exactly on the timeout count.
        ifc.CountClr = 1;
        step(); idle();
        for (int i = 0; i < 4; i++) begin
            ifc.MemReqM = 1; ifc.PCSrcE = 1;
            #1 check("mw_hold", 32'(ctl_now()), 32'(7'b1111100));
            step();
        end
        ifc.MemAckM = 1;
        #1 check("mw_ack_ctl", 32'(ctl_now()), 32'(7'b0000011));
        step(); idle();
        #1 check("mw_run_ctl", 32'(ctl_now()), 0);
        check("mw_no_err", 32'(ifc.Error), 0);
        check("mw_stallcnt", 32'(ifc.StallCount), 4);
        check("mw_flushcnt", 32'(ifc.FlushCount), 1);
        $display("memory-wait scenario done");

        // Timeout into sticky error, then asynchronous reset.
        ifc.MemReqM = 1;
        for (int i = 0; i < 5; i++) begin
            #1 check("to_pre_err", 32'(ifc.Error), 0);
            step();
        end
        check("to_err", 32'(ifc.Error), 1);
        idle(); ifc.MemAckM = 1; ifc.PCSrcE = 1;
        step(); step();
        check("to_err_sticky", 32'(ifc.Error), 1);
        check("to_err_hold", 32'(ctl_now()), 32'(7'b1111100));
        #2 reset = 1'b0;
        #1 check("async_err", 32'(ifc.Error), 0);
        check("async_stallcnt", 32'(ifc.StallCount), 0);
        check("async_flushcnt", 32'(ifc.FlushCount), 0);
        step(); idle();
        reset = 1'b1;
        #1 check("post_reset_ctl", 32'(ctl_now()), 0);
        $display("timeout scenario done");

        // Saturation and clear priority.
        step(); idle();
        for (int i = 0; i < 20; i++) begin
            ifc.ResultSrcE = 2'b01; ifc.RdE = 3; ifc.Rs1D = 3;
            step();
        end
        check("sat_stallcnt", 32'(ifc.StallCount), 15);
        ifc.CountClr = 1;
        step(); idle();
        check("clr_stallcnt", 32'(ifc.StallCount), 0);
        $display("saturation scenario done");

        // Randomized traffic; the every-cycle model compare does the checking.
        for (int c = 0; c < 3000; c++) begin
            step();
            if (!reset) begin
                reset = 1'b1;
            end else if ((m_err && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
                reset = 1'b0;
            end
            ifc.Rs1D = 5'($urandom_range(0, 3)); ifc.Rs2D = 5'($urandom_range(0, 3));
            ifc.Rs1E = 5'($urandom_range(0, 3)); ifc.Rs2E = 5'($urandom_range(0, 3));
            ifc.RdE  = 5'($urandom_range(0, 3)); ifc.RdM  = 5'($urandom_range(0, 3));
            ifc.RdW  = 5'($urandom_range(0, 3));
            ifc.RegWriteM  = 1'($urandom_range(0, 1));
            ifc.RegWriteW  = 1'($urandom_range(0, 1));
            ifc.ResultSrcE = 2'($urandom_range(0, 3));
            ifc.PCSrcE     = ($urandom_range(0, 3) == 0);
            ifc.MemReqM    = ($urandom_range(0, 3) == 0);
            ifc.MemAckM    = 1'($urandom_range(0, 1));
            ifc.CountClr   = ($urandom_range(0, 15) == 0);
        end
        step();
        $display("random phase done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
